data_mem_arbiter: RTL and testbench

// - Shares the single-port data memory between two requesters.
// - Port C is the core load/store path (ALU address, rs2 write data, rd_en/wr_en).
// - Port D is a debug/DMA loader that fills or inspects data memory while the core runs.
// - Grants one access per cycle using round-robin order.
// - Returns read data one cycle after the grant; the memory read is registered.
// - Drives core_stall so the single-cycle core holds its PC while its access is pending.

---
 rtl/data_mem_arbiter.sv | 92 +++++++++
 tb/tb_data_mem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sharing of a single-port data memory between core (C) and debug/DMA (D); define ARB_LOCK_EN to let D lock the grant for bursts
module data_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              core_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic              rr_ptr;
  logic              rd_pending;
  logic              rd_owner;
  logic              locked;
  logic              lock_hold;
  logic              pick_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
`ifdef ARB_LOCK_EN
  logic [7:0] lock_cnt;
  assign locked    = lock_cnt != 8'd0;
  assign lock_hold = d_gnt & d_lock & (lock_cnt + 8'd1 != 8'(LOCK_MAX));
  // count consecutive locked D beats; an unlocked grant or hitting the cap releases the lock
  always_ff @(posedge clk or negedge reset)
    if (!reset) lock_cnt <= 8'd0;
    else if (c_gnt | d_gnt) lock_cnt <= lock_hold ? lock_cnt + 8'd1 : 8'd0;
`else
  logic unused_lock;
  assign unused_lock = d_lock ^ (LOCK_MAX == 0);
  assign locked      = 1'b0;
  assign lock_hold   = 1'b0;
`endif
  // rr_ptr = 1 favours D; grants are suppressed while reset is held
  assign pick_d     = d_req & (~c_req | rr_ptr | locked);
  assign d_gnt      = reset & pick_d;
  assign c_gnt      = reset & c_req & ~pick_d;
  assign core_stall = reset & c_req & ~c_gnt;
  assign mem_addr   = d_gnt ? d_addr : c_gnt ? c_addr : addr_q;
  assign mem_wdata  = d_gnt ? d_wdata : c_gnt ? c_wdata : wdata_q;
  assign mem_wr_en  = (d_gnt & d_we) | (c_gnt & c_we);
  assign mem_rd_en  = (d_gnt & ~d_we) | (c_gnt & ~c_we);
  assign c_rvalid   = rd_pending & ~rd_owner;
  assign d_rvalid   = rd_pending & rd_owner;
  assign c_rdata    = c_rvalid ? mem_rdata : c_rdata_q;
  assign d_rdata    = d_rvalid ? mem_rdata : d_rdata_q;
  // arbitration pointer, read-return tracking and held memory/rdata values
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rr_ptr     <= 1'b0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      rd_pending <= mem_rd_en;
      addr_q     <= mem_addr;
      wdata_q    <= mem_wdata;
      c_rdata_q  <= c_rdata;
      d_rdata_q  <= d_rdata;
      if (mem_rd_en) rd_owner <= d_gnt;
      if ((c_gnt | d_gnt) & ~lock_hold) rr_ptr <= c_gnt;
    end
  // a pending request must hold its command steady until it is granted
  a_c_hold: assert property (@(posedge clk) disable iff (!reset)
    c_req & ~c_gnt |=> c_req & $stable(c_we) & $stable(c_addr) & $stable(c_wdata));
  a_d_hold: assert property (@(posedge clk) disable iff (!reset)
    d_req & ~d_gnt |=> d_req & $stable(d_we) & $stable(d_addr) & $stable(d_wdata));
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized and directed scoreboard bench for data_mem_arbiter against a request-level reference model
module tb_data_mem_arbiter;
  localparam int LM = 3;
  typedef struct {
    bit          idle;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          lock;
  } req_t;
  logic        clk = 0, reset = 0;
  logic        c_req = 0, c_we = 0, c_gnt, c_rvalid, core_stall;
  logic [31:0] c_addr = 0, c_wdata = 0, c_rdata;
  logic        d_req = 0, d_we = 0, d_lock = 0, d_gnt, d_rvalid;
  logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic        mem_wr_en, mem_rd_en;
  logic [31:0] mem_arr [64];
  logic [31:0] ref_mem [64];
  req_t        c_todo[$], d_todo[$];
  req_t        c_cur, d_cur;
  bit          c_busy = 0, d_busy = 0;
  logic [31:0] c_exp_q[$], d_exp_q[$];
  logic [31:0] c_last = 0, d_last = 0, exp_addr = 0, exp_wdata = 0;
  bit          exp_cg = 0, exp_dg = 0, exp_rd = 0, exp_wr = 0;
  bit          c_rd_now = 0, d_rd_now = 0, c_prev = 0, d_prev = 0;
  int          last = 1, run = 0;
  int          vectors = 0, miscompares = 0;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .core_stall(core_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) mem_arr[mem_addr[5:0]] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem_arr[mem_addr[5:0]];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic req_t mk(bit idle, bit we, int addr, logic [31:0] wdata, bit lock);
    req_t r;
    r.idle = idle; r.we = we; r.addr = 32'(addr); r.wdata = wdata; r.lock = lock;
    return r;
  endfunction

  // reference model: apply one granted access to the reference memory and the scoreboard
  task automatic apply(input req_t r, input bit is_d);
    exp_addr  = r.addr;
    exp_wdata = r.wdata;
    if (r.we) begin
      ref_mem[r.addr[5:0]] = r.wdata;
      exp_wr = 1;
    end else begin
      exp_rd = 1;
      if (is_d) begin d_exp_q.push_back(ref_mem[r.addr[5:0]]); d_rd_now = 1; end
      else begin c_exp_q.push_back(ref_mem[r.addr[5:0]]); c_rd_now = 1; end
    end
  endtask

  task automatic step();
    bit favor_d;
    @(posedge clk); #1;
    if (!c_busy && c_todo.size() > 0) begin c_cur = c_todo.pop_front(); c_busy = !c_cur.idle; end
    if (!d_busy && d_todo.size() > 0) begin d_cur = d_todo.pop_front(); d_busy = !d_cur.idle; end
    c_req = c_busy; c_we = c_cur.we; c_addr = c_cur.addr; c_wdata = c_cur.wdata;
    d_req = d_busy; d_we = d_cur.we; d_addr = d_cur.addr; d_wdata = d_cur.wdata;
    d_lock = d_busy & d_cur.lock;
    exp_rd = 0; exp_wr = 0; c_rd_now = 0; d_rd_now = 0;
    favor_d = (last == 0);
`ifdef ARB_LOCK_EN
    if (run > 0) favor_d = 1;
`endif
    exp_dg = d_busy && (!c_busy || favor_d);
    exp_cg = c_busy && !exp_dg;
    if (exp_cg) begin
      apply(c_cur, 0);
      last = 0; run = 0; c_busy = 0;
    end
    if (exp_dg) begin
      apply(d_cur, 1);
      d_busy = 0;
`ifdef ARB_LOCK_EN
      if (d_cur.lock) begin
        run++;
        if (run == LM) begin run = 0; last = 1; end
      end else begin
        run = 0; last = 1;
      end
`else
      last = 1;
`endif
    end
  endtask

  // asynchronous reset one cycle after the previous step; requests during reset must be ignored
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 0; c_req = 0; d_req = 0; d_lock = 0;
    c_busy = 0; d_busy = 0; c_todo.delete(); d_todo.delete();
    c_exp_q.delete(); d_exp_q.delete();
    c_prev = 0; d_prev = 0; c_rd_now = 0; d_rd_now = 0;
    exp_cg = 0; exp_dg = 0; exp_rd = 0; exp_wr = 0;
    exp_addr = 0; exp_wdata = 0; c_last = 0; d_last = 0; last = 1; run = 0;
    @(posedge clk); #1;
    c_req = 1; d_req = 1; c_addr = 32'h3; d_addr = 32'h4;
    @(posedge clk); #1;
    c_req = 0; d_req = 0;
    @(posedge clk); #1;
    reset = 1;
  endtask

  task automatic drain();
    int i = 0;
    while ((c_busy || d_busy || c_todo.size() > 0 || d_todo.size() > 0) && i < 3000) begin
      step();
      i++;
    end
    chk("drain_timeout", 32'(c_busy || d_busy || c_todo.size() > 0 || d_todo.size() > 0), 0);
    step();
    step();
  endtask

  // monitor: compare grants and memory drive, pop the scoreboard on every returned read
  always @(negedge clk) begin
    chk("c_gnt", c_gnt, exp_cg);
    chk("d_gnt", d_gnt, exp_dg);
    chk("core_stall", core_stall, reset & c_req & ~exp_cg);
    chk("mem_rd_en", mem_rd_en, exp_rd);
    chk("mem_wr_en", mem_wr_en, exp_wr);
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wdata", mem_wdata, exp_wdata);
    chk("c_rvalid", c_rvalid, c_prev);
    chk("d_rvalid", d_rvalid, d_prev);
    if (c_rvalid) begin
      if (c_exp_q.size() == 0) chk("c_unexpected_read", 1, 0);
      else c_last = c_exp_q.pop_front();
    end
    if (d_rvalid) begin
      if (d_exp_q.size() == 0) chk("d_unexpected_read", 1, 0);
      else d_last = d_exp_q.pop_front();
    end
    chk("c_rdata", c_rdata, c_last);
    chk("d_rdata", d_rdata, d_last);
    c_prev = c_rd_now;
    d_prev = d_rd_now;
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    repeat (2) step();
    c_todo.push_back(mk(0, 0, 32'h10, 0, 0));
    repeat (3) step();
    c_todo.push_back(mk(0, 0, 32'h5, 0, 0));
    step();
    do_reset();
    repeat (2) begin
      c_todo.push_back(mk(0, 0, $urandom_range(0, 63), 0, 0));
      d_todo.push_back(mk(0, 0, $urandom_range(0, 63), 0, 0));
    end
    drain();
    d_todo.push_back(mk(0, 1, 32'h20, 32'h55, 0));
    c_todo.push_back(mk(1, 0, 0, 0, 0));
    c_todo.push_back(mk(0, 0, 32'h20, 0, 0));
    drain();
    repeat (3) c_todo.push_back(mk(0, 0, $urandom_range(0, 63), 0, 0));
    d_todo.push_back(mk(1, 0, 0, 0, 0));
    repeat (4) d_todo.push_back(mk(0, 0, $urandom_range(0, 63), 0, 1));
    drain();
    for (int i = 0; i < 400; i++) begin
      c_todo.push_back(mk($urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 63), $urandom, 0));
      d_todo.push_back(mk($urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 63), $urandom, $urandom_range(0, 1)));
    end
    drain();
    chk("c_queue_empty", c_exp_q.size(), 0);
    chk("d_queue_empty", d_exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
